// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack bus transaction per access, extended
// load result to MEM/WB, pipeline stall while the transaction is outstanding.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        Address,
  input  logic [31:0]        Write_data,
  input  logic [4:0]         Rd,
  input  logic [2:0]         funct3,
  input  logic               MemRead_MEM,
  input  logic               MemWrite_MEM,
  mem_access_unit_if.master  mem,
  output logic [31:0]        Read_data,
  output logic [31:0]        Address_out,
  output logic [4:0]         Rd_out,
  output logic               stall,
  output logic               mem_fault
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic             req_d, we_d;
  logic [31:0]      addr_d, wdata_d, rdata_d;
  logic [3:0]       wstrb_d;

  logic             access, illegal, misaligned, bad;
  logic [31:0]      st_wdata;
  logic [3:0]       st_wstrb;

  // Select the addressed byte/half from the bus word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w,
                                          input logic [1:0]  o,
                                          input logic [2:0]  f3);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {o, 3'b000};
    b  = sh[7:0];
    h  = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'd0, b};
      3'b101:  extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  assign Address_out = Address;
  assign Rd_out      = Rd;

  // Access decode and store lane mapping.
  always_comb begin
    access     = MemRead_MEM | MemWrite_MEM;
    illegal    = (MemRead_MEM & MemWrite_MEM) |
                 (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111) |
                 (MemWrite_MEM & funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) & Address[0]) |
                 ((funct3[1:0] == 2'b10) & (Address[1:0] != 2'b00));
    bad        = illegal | misaligned;

    st_wdata = Write_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{Write_data[7:0]}};
        st_wstrb = 4'b0001 << Address[1:0];
      end
      2'b01: begin
        st_wdata = {2{Write_data[15:0]}};
        st_wstrb = Address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    off_d   = off_q;
    f3_d    = f3_q;
    req_d   = mem.mem_req;
    we_d    = mem.mem_we;
    addr_d  = mem.mem_addr;
    wdata_d = mem.mem_wdata;
    wstrb_d = mem.mem_wstrb;
    rdata_d = Read_data;

    case (state_q)
      IDLE: begin
        rdata_d = 32'd0;
        fault_d = 1'b0;
        cnt_d   = '0;
        if (access && !bad) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = MemWrite_MEM;
          addr_d  = {Address[31:2], 2'b00};
          wdata_d = st_wdata;
          wstrb_d = MemWrite_MEM ? st_wstrb : 4'b0000;
          off_d   = Address[1:0];
          f3_d    = funct3;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack on the last allowed cycle still wins over the timeout.
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          rdata_d = mem.mem_we ? 32'd0 : extract(mem.mem_rdata, off_q, f3_q);
          state_d = RESP;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          rdata_d = 32'd0;
          fault_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = 32'd0;
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      fault_q       <= 1'b0;
      off_q         <= 2'b00;
      f3_q          <= 3'b000;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_wdata <= 32'd0;
      mem.mem_wstrb <= 4'b0000;
      Read_data     <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fault_q       <= fault_d;
      off_q         <= off_d;
      f3_q          <= f3_d;
      mem.mem_req   <= req_d;
      mem.mem_we    <= we_d;
      mem.mem_addr  <= addr_d;
      mem.mem_wdata <= wdata_d;
      mem.mem_wstrb <= wstrb_d;
      Read_data     <= rdata_d;
    end
  end

  // Stall and fault are suppressed while reset is held.
  always_comb begin
    stall     = 1'b0;
    mem_fault = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          stall     = access & ~bad;
          mem_fault = access & bad;
        end
        BUSY:    stall = 1'b1;
        RESP:    mem_fault = fault_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through a
// scoreboard queue, plus hand sequences for reset behaviour.
module tb_mem_access_unit;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, Write_data;
  logic [4:0]  Rd;
  logic [2:0]  funct3;
  logic        MemRead_MEM, MemWrite_MEM;
  logic [31:0] Read_data, Address_out;
  logic [4:0]  Rd_out;
  logic        stall, mem_fault;

  mem_access_unit_if bus ();

  mem_access_unit #(.ACK_TIMEOUT(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .Address      (Address),
    .Write_data   (Write_data),
    .Rd           (Rd),
    .funct3       (funct3),
    .MemRead_MEM  (MemRead_MEM),
    .MemWrite_MEM (MemWrite_MEM),
    .mem          (bus.master),
    .Read_data    (Read_data),
    .Address_out  (Address_out),
    .Rd_out       (Rd_out),
    .stall        (stall),
    .mem_fault    (mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [4:0]  rdr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] rdata;
    int          delay;      // BUSY cycles before ack; >= T means never
    logic        bad;        // immediate fault in IDLE
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        exp_fault;  // fault seen in RESP
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  vec_t sb_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b0;
    bus.mem_ack  = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    vec_t e;
    int   stall_cycles;
    int   exp_cycles;
    int   busy_idx;
    bit   done;
    @(negedge clk);
    Address = v.addr; Write_data = v.wdata; Rd = v.rdr; funct3 = v.f3;
    MemRead_MEM = v.rd_en; MemWrite_MEM = v.wr_en;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;
    #1;
    if (v.bad) begin
      chk("bad_stall", stall, 1'b0);
      chk("bad_fault", mem_fault, 1'b1);
      chk("bad_rdata", Read_data, 32'd0);
      @(posedge clk); #1;
      chk("bad_noreq", bus.mem_req, 1'b0);
      idle_inputs();
      return;
    end
    sb_q.push_back(v);
    chk("req_stall", stall, 1'b1);
    stall_cycles = 1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (stall !== 1'b1) begin
        done = 1'b1;
      end else if (stall_cycles > 64) begin
        chk("busy_bound", 32'(stall_cycles), 32'd0);
        done = 1'b1;
      end else begin
        stall_cycles++;
        busy_idx = stall_cycles - 2;
        chk("busy_req", bus.mem_req, 1'b1);
        if (busy_idx == 0 && sb_q.size() > 0) begin
          e = sb_q[0];
          chk("bus_addr", bus.mem_addr, e.exp_addr);
          chk("bus_we", bus.mem_we, e.exp_we);
          chk("bus_wstrb", bus.mem_wstrb, e.exp_wstrb);
          if (e.exp_we) chk("bus_wdata", bus.mem_wdata, e.exp_wdata);
        end
        if (busy_idx == v.delay) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = v.rdata;
        end else begin
          bus.mem_ack = 1'b0;
        end
      end
    end
    bus.mem_ack = 1'b0;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      exp_cycles = (e.delay >= int'(T)) ? int'(T) + 1 : e.delay + 2;
      chk("latency", 32'(stall_cycles), 32'(exp_cycles));
      chk("resp_stall", stall, 1'b0);
      chk("resp_rdata", Read_data, e.exp_rdata);
      chk("resp_fault", mem_fault, e.exp_fault);
      chk("resp_req", bus.mem_req, 1'b0);
      chk("resp_addr_out", Address_out, e.addr);
      chk("resp_rd_out", 32'(Rd_out), 32'(e.rdr));
    end
    idle_inputs();
    @(negedge clk); #1;
    chk("idle_stall", stall, 1'b0);
    chk("idle_fault", mem_fault, 1'b0);
    chk("idle_rdata", Read_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            addr   wdata        f3     rd  r  w  rdata        dly bad eaddr  ewdata       strb   we erdata      ef
    vecs[0]  = '{32'h100, 32'h0,        3'b010, 1, 1, 0, 32'hDEADBEEF, 0,   0, 32'h100, 32'h0,        4'h0, 0, 32'hDEADBEEF, 0};
    vecs[1]  = '{32'h103, 32'h0,        3'b000, 2, 1, 0, 32'h80FFFF7F, 0,   0, 32'h100, 32'h0,        4'h0, 0, 32'hFFFFFF80, 0};
    vecs[2]  = '{32'h103, 32'h0,        3'b100, 3, 1, 0, 32'h80FFFF7F, 0,   0, 32'h100, 32'h0,        4'h0, 0, 32'h00000080, 0};
    vecs[3]  = '{32'h102, 32'h0,        3'b001, 4, 1, 0, 32'h80FFFF7F, 0,   0, 32'h100, 32'h0,        4'h0, 0, 32'hFFFF80FF, 0};
    vecs[4]  = '{32'h102, 32'h0,        3'b101, 5, 1, 0, 32'h80FFFF7F, 0,   0, 32'h100, 32'h0,        4'h0, 0, 32'h000080FF, 0};
    vecs[5]  = '{32'h201, 32'h12345678, 3'b000, 6, 0, 1, 32'h0,        0,   0, 32'h200, 32'h78787878, 4'h2, 1, 32'h0,        0};
    vecs[6]  = '{32'h202, 32'h12345678, 3'b001, 7, 0, 1, 32'h0,        0,   0, 32'h200, 32'h56785678, 4'hC, 1, 32'h0,        0};
    vecs[7]  = '{32'h304, 32'hCAFEF00D, 3'b010, 8, 0, 1, 32'h0,        2,   0, 32'h304, 32'hCAFEF00D, 4'hF, 1, 32'h0,        0};
    vecs[8]  = '{32'h102, 32'h0,        3'b010, 9, 1, 0, 32'h0,        0,   1, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0};
    vecs[9]  = '{32'h203, 32'h12345678, 3'b001, 10, 0, 1, 32'h0,       0,   1, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0};
    vecs[10] = '{32'h101, 32'h0,        3'b000, 11, 1, 0, 32'h00007F00, 1,  0, 32'h100, 32'h0,        4'h0, 0, 32'h0000007F, 0};
    vecs[11] = '{32'h100, 32'h0,        3'b011, 12, 1, 0, 32'h0,       0,   1, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0};
    vecs[12] = '{32'h100, 32'h0,        3'b100, 13, 0, 1, 32'h0,       0,   1, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0};
    vecs[13] = '{32'h100, 32'h0,        3'b010, 14, 1, 1, 32'h0,       0,   1, 32'h0,   32'h0,        4'h0, 0, 32'h0,        0};
    vecs[14] = '{32'h400, 32'h0,        3'b010, 15, 1, 0, 32'h0,       255, 0, 32'h400, 32'h0,        4'h0, 0, 32'h0,        1};
    vecs[15] = '{32'h404, 32'h0,        3'b010, 16, 1, 0, 32'h11223344, 0,  0, 32'h404, 32'h0,        4'h0, 0, 32'h11223344, 0};
    vecs[16] = '{32'h100, 32'h0,        3'b001, 17, 1, 0, 32'h12348001, 3,  0, 32'h100, 32'h0,        4'h0, 0, 32'hFFFF8001, 0};
    vecs[17] = '{32'h207, 32'hAABBCCDD, 3'b000, 18, 0, 1, 32'h0,       1,   0, 32'h204, 32'hDDDDDDDD, 4'h8, 1, 32'h0,        0};

    reset = 1'b0;
    Address = 32'h0000_0ABC; Write_data = 32'd0; Rd = 5'd3; funct3 = 3'b010;
    bus.mem_rdata = 32'd0;
    idle_inputs();
    #1;
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_wstrb", bus.mem_wstrb, 4'd0);
    chk("rst_rdata", Read_data, 32'd0);
    chk("rst_stall", stall, 1'b0);
    chk("addr_pass", Address_out, 32'h0000_0ABC);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) run_op(vecs[i]);

    // Reset asserted in the third BUSY cycle aborts the access.
    @(negedge clk);
    Address = 32'h500; funct3 = 3'b010; Rd = 5'd20;
    MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_req", bus.mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("arst_req", bus.mem_req, 1'b0);
    chk("arst_stall", stall, 1'b0);
    chk("arst_fault", mem_fault, 1'b0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("late_ack_req", bus.mem_req, 1'b0);
    chk("late_ack_rdata", Read_data, 32'd0);
    chk("late_ack_stall", stall, 1'b0);

    // The unit is still usable after the aborted access.
    run_op(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit of the 5-stage RISC-V pipeline. It sits between the EX/MEM register and the MEM/WB register. It takes the ALU-computed address, store data and memory controls, and runs a req/ack transaction on the data-memory bus. It then delivers a byte/half/word-extended load result plus pass-through Address/Rd to MEM/WB, and stalls the upstream stages while a transaction is outstanding.

## Interface
Parameters:
- ACK_TIMEOUT, 16: number of BUSY cycles without mem_ack before the access is aborted with a fault (range 1..255).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Address  in  32  effective address (ALU result) from EX/MEM.
- Write_data  in  32  store data (rs2) from EX/MEM.
- Rd  in  5  destination register from EX/MEM.
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- MemRead_MEM, MemWrite_MEM  in  1 each  load / store request. Both high is treated as an illegal access.
- mem_ack  in  1  memory bus acknowledge, sampled only in BUSY.
- mem_rdata  in  32  memory read word, valid when mem_ack=1.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write, registered.
- mem_addr  out  32  word-aligned address {Address[31:2],2'b00}, registered.
- mem_wdata  out  32  lane-aligned store data, registered.
- mem_wstrb  out  4  byte write strobes, registered; 0 on loads.
- Read_data  out  32  extended load result to MEM/WB, registered.
- Address_out  out  32  combinational copy of Address.
- Rd_out  out  5  combinational copy of Rd.
- stall  out  1  combinational; 1 = hold PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_fault  out  1  combinational; misaligned, illegal or timed-out access, valid while stall=0.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE with no access (MemRead_MEM=MemWrite_MEM=0): pass-through, stall=0, Read_data holds 0, mem_fault=0.
- IDLE with a legal, aligned access:
  - stall=1.
  - On the next edge: mem_req=1, mem_we=MemWrite_MEM, mem_addr, mem_wdata and mem_wstrb latched; go to BUSY; timeout counter cleared.
- Illegal or misaligned access in IDLE:
  - Illegal: funct3 011/110/111 with any request, funct3 100/101 on a store, or both requests set.
  - Misaligned: half access with Address[0]=1, word access with Address[1:0]!=0.
  - Response: no bus transaction, stall=0, mem_fault=1, Read_data=0, stay in IDLE.
- Store lane mapping (o = Address[1:0]):
  - SB: wdata = byte replicated x4, wstrb = 4'b0001<<o.
  - SH: wdata = half replicated x2, wstrb = 0011 (o=0) or 1100 (o=2).
  - SW: wdata = Write_data, wstrb = 1111.
- BUSY:
  - Outputs held stable, stall=1, counter increments each cycle.
  - mem_ack=1: mem_req drops to 0 on that edge; for a load, Read_data captures mem_rdata selected by o and sign/zero-extended per funct3; for a store, Read_data=0. Go to RESP.
  - Counter reaches ACK_TIMEOUT without ack: mem_req drops, Read_data=0, fault latched, go to RESP.
- RESP: stall=0 for exactly one cycle. MEM/WB captures Read_data, Address_out, Rd_out. mem_fault reflects the latched timeout flag. Go to IDLE; the latched fault clears.
- mem_ack outside BUSY is ignored.

## Timing
- Reset asserted (low): immediately state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, Read_data=0, counter=0, fault flag=0. stall and mem_fault are forced to 0 while reset is low.
- Reset mid-BUSY aborts the transaction; a later mem_ack is ignored.
- Load/store latency with ack in the first BUSY cycle: cycle 0 IDLE (stall=1), cycle 1 BUSY (mem_req=1, ack), cycle 2 RESP (stall=0, result valid). Each extra wait cycle adds one cycle.
- Timeout: RESP is entered ACK_TIMEOUT+1 cycles after the IDLE request cycle.
- Upstream inputs must stay stable while stall=1; the unit does not re-sample them in BUSY.
- Back-to-back accesses: after RESP, the next instruction is evaluated in IDLE on the following cycle, giving a minimum spacing of 3 cycles per memory op.

## Test plan
- LW at 0x100, mem_rdata=0xDEADBEEF, ack in first BUSY cycle: mem_addr=0x100, wstrb=0; RESP in cycle 2 with Read_data=0xDEADBEEF; stall=1,1,0.
- LB at 0x103 with mem_rdata=0x80FF_FF7F gives Read_data=0xFFFFFF80; LBU gives 0x00000080; LH at 0x102 gives 0xFFFF80FF; LHU at 0x102 gives 0x000080FF.
- SB at 0x201, Write_data=0x12345678: mem_addr=0x200, wdata=0x78787878, wstrb=0010, mem_we=1; SH at 0x202 gives wstrb=1100, wdata=0x56785678.
- LW at 0x102 or SH at 0x203: no mem_req, stall=0, mem_fault=1 in the same cycle, Read_data=0.
- No ack with ACK_TIMEOUT=4: mem_req high 4 cycles then 0; RESP with mem_fault=1, Read_data=0. A subsequent LW completes normally with mem_fault=0.
- reset pulled low in the 3rd BUSY cycle: mem_req falls asynchronously, and an ack 1 cycle after reset release is ignored (state IDLE, Read_data=0).
